// File: rtl/msgPass_config_pkg.sv
// Message-passing buffer configuration constants.
// Supplies the default message and address widths shared by the buffer
// macro and its access controller.
package msgPass_config_pkg;

  localparam int unsigned MSGPASS_BUFF_RDATA_WIDTH = 16;
  localparam int unsigned MSGPASS_BUFF_ADDR_WIDTH  = 8;

endpackage

// File: rtl/msgpass_buffer_ctrl.sv
// msgpass_buffer_ctrl
// Access controller for the dual-port message-passing buffer. Arbitrates two
// write channels and two read channels (valid/ready), issues registered
// commands to the buffer pins one cycle after each grant and returns read
// data two cycles after each read grant.
//
// Ports
//   clk_i, rstn                 clock (buffer read + write clock), async active-low reset
//   wreq_{a,b}_*                write request channels: valid, ready (comb), addr, data
//   rreq_{a,b}_*                read request channels: valid, ready (comb), addr
//   rresp_{a,b}_*               read response: 1-cycle valid pulse, data
//   buf_cen_o                   buffer read enable (1 = read clock/outputs enabled)
//   buf_wen_{a,b}_o             buffer write enables, active low
//   buf_waddr/wdata_{a,b}_o     buffer write address/data
//   buf_raddr_{a,b}_o           buffer read address
//   buf_rdata_{a,b}_i           buffer read data
//   buf_write_conflict_i        buffer same-address write flag
//   err_conflict_o              sticky conflict error
//
// Optional build macro MSGPASS_CTRL_STAT_EN adds 16-bit saturating stall
// counters stat_ww_stall_o and stat_rw_stall_o.
module msgpass_buffer_ctrl #(
  parameter int unsigned DATA_WIDTH = msgPass_config_pkg::MSGPASS_BUFF_RDATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = msgPass_config_pkg::MSGPASS_BUFF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rstn,

  input  logic                  wreq_a_valid_i,
  output logic                  wreq_a_ready_o,
  input  logic [ADDR_WIDTH-1:0] wreq_a_addr_i,
  input  logic [DATA_WIDTH-1:0] wreq_a_data_i,
  input  logic                  wreq_b_valid_i,
  output logic                  wreq_b_ready_o,
  input  logic [ADDR_WIDTH-1:0] wreq_b_addr_i,
  input  logic [DATA_WIDTH-1:0] wreq_b_data_i,

  input  logic                  rreq_a_valid_i,
  output logic                  rreq_a_ready_o,
  input  logic [ADDR_WIDTH-1:0] rreq_a_addr_i,
  input  logic                  rreq_b_valid_i,
  output logic                  rreq_b_ready_o,
  input  logic [ADDR_WIDTH-1:0] rreq_b_addr_i,

  output logic                  rresp_a_valid_o,
  output logic [DATA_WIDTH-1:0] rresp_a_data_o,
  output logic                  rresp_b_valid_o,
  output logic [DATA_WIDTH-1:0] rresp_b_data_o,

  output logic                  buf_cen_o,
  output logic                  buf_wen_a_o,
  output logic                  buf_wen_b_o,
  output logic [ADDR_WIDTH-1:0] buf_waddr_a_o,
  output logic [ADDR_WIDTH-1:0] buf_waddr_b_o,
  output logic [DATA_WIDTH-1:0] buf_wdata_a_o,
  output logic [DATA_WIDTH-1:0] buf_wdata_b_o,
  output logic [ADDR_WIDTH-1:0] buf_raddr_a_o,
  output logic [ADDR_WIDTH-1:0] buf_raddr_b_o,
  input  logic [DATA_WIDTH-1:0] buf_rdata_a_i,
  input  logic [DATA_WIDTH-1:0] buf_rdata_b_i,
  input  logic                  buf_write_conflict_i,
  output logic                  err_conflict_o
`ifdef MSGPASS_CTRL_STAT_EN
  ,
  output logic [15:0]           stat_ww_stall_o,
  output logic [15:0]           stat_rw_stall_o
`endif
);

  // ---------------------------------------------------------------------------
  // Grant logic (combinational)
  // ---------------------------------------------------------------------------
  logic wa_gnt;
  logic wb_gnt;
  logic ra_gnt;
  logic rb_gnt;
  logic ww_addr_eq;
  logic ra_hit_wb;
  logic rb_hit_wa;

  always_comb begin
    ww_addr_eq = (wreq_a_addr_i == wreq_b_addr_i);

    // A always wins a same-address write pair; B lands one cycle later so
    // B's data is the final value and the buffer never sees a conflict.
    wreq_a_ready_o = rstn;
    wreq_b_ready_o = rstn & ~(wreq_a_valid_i & ww_addr_eq);

    wa_gnt = wreq_a_valid_i & wreq_a_ready_o;
    wb_gnt = wreq_b_valid_i & wreq_b_ready_o;

    // A granted write on the read's own port blocks the read outright, which
    // also covers the same-port address match; only the cross-port write
    // needs an explicit address compare for the read-after-write stall.
    ra_hit_wb = wb_gnt & (wreq_b_addr_i == rreq_a_addr_i);
    rb_hit_wa = wa_gnt & (wreq_a_addr_i == rreq_b_addr_i);

    rreq_a_ready_o = rstn & ~wa_gnt & ~ra_hit_wb;
    rreq_b_ready_o = rstn & ~wb_gnt & ~rb_hit_wa;

    ra_gnt = rreq_a_valid_i & rreq_a_ready_o;
    rb_gnt = rreq_b_valid_i & rreq_b_ready_o;
  end

  // ---------------------------------------------------------------------------
  // Issue / response pipeline next-state
  // ---------------------------------------------------------------------------
  logic                  rd_iss_a_q;
  logic                  rd_iss_b_q;
  logic                  rd_iss_a_d;
  logic                  rd_iss_b_d;
  logic                  wen_a_d;
  logic                  wen_b_d;
  logic [ADDR_WIDTH-1:0] waddr_a_d;
  logic [ADDR_WIDTH-1:0] waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_a_d;
  logic [DATA_WIDTH-1:0] wdata_b_d;
  logic [ADDR_WIDTH-1:0] raddr_a_d;
  logic [ADDR_WIDTH-1:0] raddr_b_d;
  logic                  rvalid_a_d;
  logic                  rvalid_b_d;
  logic                  cen_d;
  logic                  err_d;

  always_comb begin
    // Buffer address/data hold their last values when idle.
    wen_a_d    = 1'b1;
    wen_b_d    = 1'b1;
    waddr_a_d  = buf_waddr_a_o;
    waddr_b_d  = buf_waddr_b_o;
    wdata_a_d  = buf_wdata_a_o;
    wdata_b_d  = buf_wdata_b_o;
    raddr_a_d  = buf_raddr_a_o;
    raddr_b_d  = buf_raddr_b_o;
    rd_iss_a_d = ra_gnt;
    rd_iss_b_d = rb_gnt;
    rvalid_a_d = rd_iss_a_q;
    rvalid_b_d = rd_iss_b_q;
    err_d      = err_conflict_o | buf_write_conflict_i;

    if (wa_gnt) begin
      wen_a_d   = 1'b0;
      waddr_a_d = wreq_a_addr_i;
      wdata_a_d = wreq_a_data_i;
    end
    if (wb_gnt) begin
      wen_b_d   = 1'b0;
      waddr_b_d = wreq_b_addr_i;
      wdata_b_d = wreq_b_data_i;
    end
    if (ra_gnt) begin
      raddr_a_d = rreq_a_addr_i;
    end
    if (rb_gnt) begin
      raddr_b_d = rreq_b_addr_i;
    end

    // Read enable covers the issue cycle and the following data cycle,
    // since the buffer gates its read outputs with cen.
    cen_d = ra_gnt | rb_gnt | rd_iss_a_q | rd_iss_b_q;
  end

  // Pipeline registers; reset flushes any read in flight.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      buf_wen_a_o     <= 1'b1;
      buf_wen_b_o     <= 1'b1;
      buf_waddr_a_o   <= '0;
      buf_waddr_b_o   <= '0;
      buf_wdata_a_o   <= '0;
      buf_wdata_b_o   <= '0;
      buf_raddr_a_o   <= '0;
      buf_raddr_b_o   <= '0;
      buf_cen_o       <= 1'b0;
      rd_iss_a_q      <= 1'b0;
      rd_iss_b_q      <= 1'b0;
      rresp_a_valid_o <= 1'b0;
      rresp_b_valid_o <= 1'b0;
      err_conflict_o  <= 1'b0;
    end else begin
      buf_wen_a_o     <= wen_a_d;
      buf_wen_b_o     <= wen_b_d;
      buf_waddr_a_o   <= waddr_a_d;
      buf_waddr_b_o   <= waddr_b_d;
      buf_wdata_a_o   <= wdata_a_d;
      buf_wdata_b_o   <= wdata_b_d;
      buf_raddr_a_o   <= raddr_a_d;
      buf_raddr_b_o   <= raddr_b_d;
      buf_cen_o       <= cen_d;
      rd_iss_a_q      <= rd_iss_a_d;
      rd_iss_b_q      <= rd_iss_b_d;
      rresp_a_valid_o <= rvalid_a_d;
      rresp_b_valid_o <= rvalid_b_d;
      err_conflict_o  <= err_d;
    end
  end

  // Response data comes straight from the buffer in the cycle after capture.
  always_comb begin
    rresp_a_data_o = rresp_a_valid_o ? buf_rdata_a_i : '0;
    rresp_b_data_o = rresp_b_valid_o ? buf_rdata_b_i : '0;
  end

`ifdef MSGPASS_CTRL_STAT_EN
  // ---------------------------------------------------------------------------
  // Saturating stall counters
  // ---------------------------------------------------------------------------
  localparam int unsigned STAT_W     = 16;
  localparam int unsigned STAT_SUM_W = STAT_W + 1;

  logic              ww_stall;
  logic [1:0]        rw_stall_cnt;
  logic [STAT_W:0]   ww_sum;
  logic [STAT_W:0]   rw_sum;
  logic [STAT_W-1:0] stat_ww_d;
  logic [STAT_W-1:0] stat_rw_d;

  always_comb begin
    ww_stall     = wreq_b_valid_i & ~wreq_b_ready_o;
    rw_stall_cnt = {1'b0, rreq_a_valid_i & ~rreq_a_ready_o}
                 + {1'b0, rreq_b_valid_i & ~rreq_b_ready_o};
    ww_sum       = {1'b0, stat_ww_stall_o} + STAT_SUM_W'(ww_stall);
    rw_sum       = {1'b0, stat_rw_stall_o} + STAT_SUM_W'(rw_stall_cnt);
    stat_ww_d    = ww_sum[STAT_W] ? {STAT_W{1'b1}} : ww_sum[STAT_W-1:0];
    stat_rw_d    = rw_sum[STAT_W] ? {STAT_W{1'b1}} : rw_sum[STAT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      stat_ww_stall_o <= '0;
      stat_rw_stall_o <= '0;
    end else begin
      stat_ww_stall_o <= stat_ww_d;
      stat_rw_stall_o <= stat_rw_d;
    end
  end
`endif

endmodule

// File: tb/tb_msgpass_buffer_ctrl.sv
// Testbench for msgpass_buffer_ctrl: directed vectors, scoreboard of read
// responses checked by an independent monitor, plus a behavioural buffer.
module tb_msgpass_buffer_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  logic          clk_i = 1'b0;
  logic          rstn;
  logic          wreq_a_valid_i, wreq_b_valid_i;
  logic          wreq_a_ready_o, wreq_b_ready_o;
  logic [AW-1:0] wreq_a_addr_i, wreq_b_addr_i;
  logic [DW-1:0] wreq_a_data_i, wreq_b_data_i;
  logic          rreq_a_valid_i, rreq_b_valid_i;
  logic          rreq_a_ready_o, rreq_b_ready_o;
  logic [AW-1:0] rreq_a_addr_i, rreq_b_addr_i;
  logic          rresp_a_valid_o, rresp_b_valid_o;
  logic [DW-1:0] rresp_a_data_o, rresp_b_data_o;
  logic          buf_cen_o, buf_wen_a_o, buf_wen_b_o;
  logic [AW-1:0] buf_waddr_a_o, buf_waddr_b_o, buf_raddr_a_o, buf_raddr_b_o;
  logic [DW-1:0] buf_wdata_a_o, buf_wdata_b_o;
  logic [DW-1:0] buf_rdata_a_i, buf_rdata_b_i;
  logic          buf_write_conflict_i;
  logic          err_conflict_o;

  msgpass_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rstn(rstn),
    .wreq_a_valid_i(wreq_a_valid_i), .wreq_a_ready_o(wreq_a_ready_o),
    .wreq_a_addr_i(wreq_a_addr_i), .wreq_a_data_i(wreq_a_data_i),
    .wreq_b_valid_i(wreq_b_valid_i), .wreq_b_ready_o(wreq_b_ready_o),
    .wreq_b_addr_i(wreq_b_addr_i), .wreq_b_data_i(wreq_b_data_i),
    .rreq_a_valid_i(rreq_a_valid_i), .rreq_a_ready_o(rreq_a_ready_o),
    .rreq_a_addr_i(rreq_a_addr_i),
    .rreq_b_valid_i(rreq_b_valid_i), .rreq_b_ready_o(rreq_b_ready_o),
    .rreq_b_addr_i(rreq_b_addr_i),
    .rresp_a_valid_o(rresp_a_valid_o), .rresp_a_data_o(rresp_a_data_o),
    .rresp_b_valid_o(rresp_b_valid_o), .rresp_b_data_o(rresp_b_data_o),
    .buf_cen_o(buf_cen_o), .buf_wen_a_o(buf_wen_a_o), .buf_wen_b_o(buf_wen_b_o),
    .buf_waddr_a_o(buf_waddr_a_o), .buf_waddr_b_o(buf_waddr_b_o),
    .buf_wdata_a_o(buf_wdata_a_o), .buf_wdata_b_o(buf_wdata_b_o),
    .buf_raddr_a_o(buf_raddr_a_o), .buf_raddr_b_o(buf_raddr_b_o),
    .buf_rdata_a_i(buf_rdata_a_i), .buf_rdata_b_i(buf_rdata_b_i),
    .buf_write_conflict_i(buf_write_conflict_i), .err_conflict_o(err_conflict_o)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } exp_t;

  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [DW-1:0] ra_exp, rb_exp;
  logic [31:0]   cyc = 32'd0;
  int            nvec = 0;
  int            nerr = 0;
  logic          ga, gb, gra, grb;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 32'd1;

  // Behavioural buffer: synchronous write (active-low wen), synchronous
  // read captured while cen is high, read outputs gated by cen.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rdata_a_q = '0;
  logic [DW-1:0] rdata_b_q = '0;
  always @(posedge clk_i) begin
    if (!buf_wen_a_o) mem[buf_waddr_a_o] <= buf_wdata_a_o;
    if (!buf_wen_b_o) mem[buf_waddr_b_o] <= buf_wdata_b_o;
    if (buf_cen_o) begin
      rdata_a_q <= mem[buf_raddr_a_o];
      rdata_b_q <= mem[buf_raddr_b_o];
    end
  end
  assign buf_rdata_a_i = buf_cen_o ? rdata_a_q : '0;
  assign buf_rdata_b_i = buf_cen_o ? rdata_b_q : '0;
  assign buf_write_conflict_i = !buf_wen_a_o && !buf_wen_b_o &&
                                (buf_waddr_a_o == buf_waddr_b_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Records the handshakes of the coming edge, queues expected responses,
  // then returns at the following falling edge.
  task automatic tick();
    #4;
    ga  = wreq_a_valid_i && wreq_a_ready_o;
    gb  = wreq_b_valid_i && wreq_b_ready_o;
    gra = rreq_a_valid_i && rreq_a_ready_o;
    grb = rreq_b_valid_i && rreq_b_ready_o;
    if (gra) q_a.push_back('{data: ra_exp, cyc: cyc + 32'd2});
    if (grb) q_b.push_back('{data: rb_exp, cyc: cyc + 32'd2});
    @(negedge clk_i);
  endtask

  task automatic idle();
    wreq_a_valid_i = 1'b0; wreq_b_valid_i = 1'b0;
    rreq_a_valid_i = 1'b0; rreq_b_valid_i = 1'b0;
    tick();
  endtask

  // Monitor: pops the scoreboard on every response, flags unexpected and
  // overdue responses.
  always @(negedge clk_i) begin
    exp_t e;
    if (rresp_a_valid_o) begin
      nvec++;
      if (q_a.size() == 0) begin
        nerr++;
        $display("FAIL rresp_a_unexpected: data %0h at cycle %0d, expected no response", rresp_a_data_o, cyc);
      end else begin
        e = q_a.pop_front();
        if (rresp_a_data_o !== e.data || cyc !== e.cyc) begin
          nerr++;
          $display("FAIL rresp_a: got data %0h cycle %0d, expected data %0h cycle %0d", rresp_a_data_o, cyc, e.data, e.cyc);
        end
      end
    end else if (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
      nvec++; nerr++;
      e = q_a.pop_front();
      $display("FAIL rresp_a_missing: got no response at cycle %0d, expected data %0h", cyc, e.data);
    end
    if (rresp_b_valid_o) begin
      nvec++;
      if (q_b.size() == 0) begin
        nerr++;
        $display("FAIL rresp_b_unexpected: data %0h at cycle %0d, expected no response", rresp_b_data_o, cyc);
      end else begin
        e = q_b.pop_front();
        if (rresp_b_data_o !== e.data || cyc !== e.cyc) begin
          nerr++;
          $display("FAIL rresp_b: got data %0h cycle %0d, expected data %0h cycle %0d", rresp_b_data_o, cyc, e.data, e.cyc);
        end
      end
    end else if (q_b.size() != 0 && q_b[0].cyc <= cyc) begin
      nvec++; nerr++;
      e = q_b.pop_front();
      $display("FAIL rresp_b_missing: got no response at cycle %0d, expected data %0h", cyc, e.data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn = 1'b1;
    wreq_a_valid_i = 1'b0; wreq_b_valid_i = 1'b0;
    rreq_a_valid_i = 1'b0; rreq_b_valid_i = 1'b0;
    wreq_a_addr_i = '0; wreq_b_addr_i = '0; wreq_a_data_i = '0; wreq_b_data_i = '0;
    rreq_a_addr_i = '0; rreq_b_addr_i = '0;
    ra_exp = '0; rb_exp = '0;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset state
    chk("rst_wen_a", 32'(buf_wen_a_o), 32'd1);
    chk("rst_wen_b", 32'(buf_wen_b_o), 32'd1);
    chk("rst_cen", 32'(buf_cen_o), 32'd0);
    chk("rst_waddr_a", 32'(buf_waddr_a_o), 32'd0);
    chk("rst_wdata_b", 32'(buf_wdata_b_o), 32'd0);
    chk("rst_raddr_a", 32'(buf_raddr_a_o), 32'd0);
    chk("rst_rvalid_a", 32'(rresp_a_valid_o), 32'd0);
    chk("rst_err", 32'(err_conflict_o), 32'd0);
    chk("rst_wready_a", 32'(wreq_a_ready_o), 32'd0);
    chk("rst_rready_b", 32'(rreq_b_ready_o), 32'd0);
    rstn = 1'b1;
    idle();
    chk("idle_wready_a", 32'(wreq_a_ready_o), 32'd1);
    chk("idle_wready_b", 32'(wreq_b_ready_o), 32'd1);
    chk("idle_wen_a", 32'(buf_wen_a_o), 32'd1);

    // Write then read-after-write on A
    wreq_a_valid_i = 1'b1; wreq_a_addr_i = 8'h10; wreq_a_data_i = 16'hBEEF;
    tick();
    chk("t1_wgrant_a", 32'(ga), 32'd1);
    chk("t1_wen_a", 32'(buf_wen_a_o), 32'd0);
    chk("t1_waddr_a", 32'(buf_waddr_a_o), 32'h10);
    chk("t1_wdata_a", 32'(buf_wdata_a_o), 32'hBEEF);
    wreq_a_valid_i = 1'b0;
    rreq_a_valid_i = 1'b1; rreq_a_addr_i = 8'h10; ra_exp = 16'hBEEF;
    tick();
    chk("t1_rgrant_a", 32'(gra), 32'd1);
    chk("t1_rd_wen_a", 32'(buf_wen_a_o), 32'd1);
    chk("t1_raddr_a", 32'(buf_raddr_a_o), 32'h10);
    chk("t1_cen", 32'(buf_cen_o), 32'd1);
    rreq_a_valid_i = 1'b0;
    idle(); idle();
    chk("t1_waddr_hold", 32'(buf_waddr_a_o), 32'h10);

    // Same-address write pair
    wreq_a_valid_i = 1'b1; wreq_a_addr_i = 8'h22; wreq_a_data_i = 16'h1111;
    wreq_b_valid_i = 1'b1; wreq_b_addr_i = 8'h22; wreq_b_data_i = 16'h2222;
    tick();
    chk("t2_wgrant_a", 32'(ga), 32'd1);
    chk("t2_wstall_b", 32'(gb), 32'd0);
    chk("t2_wen_a", 32'(buf_wen_a_o), 32'd0);
    chk("t2_wen_b_idle", 32'(buf_wen_b_o), 32'd1);
    chk("t2_wdata_a", 32'(buf_wdata_a_o), 32'h1111);
    wreq_a_valid_i = 1'b0;
    tick();
    chk("t2_wgrant_b", 32'(gb), 32'd1);
    chk("t2_wen_b", 32'(buf_wen_b_o), 32'd0);
    chk("t2_wen_a_idle", 32'(buf_wen_a_o), 32'd1);
    chk("t2_waddr_b", 32'(buf_waddr_b_o), 32'h22);
    chk("t2_wdata_b", 32'(buf_wdata_b_o), 32'h2222);
    wreq_b_valid_i = 1'b0;
    rreq_a_valid_i = 1'b1; rreq_a_addr_i = 8'h22; ra_exp = 16'h2222;
    tick();
    chk("t2_rgrant_a", 32'(gra), 32'd1);
    rreq_a_valid_i = 1'b0;
    idle(); idle();
    chk("t2_err", 32'(err_conflict_o), 32'd0);

    // Cross-port read-after-write stall
    wreq_b_valid_i = 1'b1; wreq_b_addr_i = 8'h30; wreq_b_data_i = 16'h3333;
    rreq_a_valid_i = 1'b1; rreq_a_addr_i = 8'h30; ra_exp = 16'h3333;
    tick();
    chk("t3_wgrant_b", 32'(gb), 32'd1);
    chk("t3_rstall_a", 32'(gra), 32'd0);
    wreq_b_valid_i = 1'b0;
    tick();
    chk("t3_rgrant_a", 32'(gra), 32'd1);
    rreq_a_valid_i = 1'b0;
    idle(); idle();

    // Same-port write/read collision, different addresses
    wreq_a_valid_i = 1'b1; wreq_a_addr_i = 8'h40; wreq_a_data_i = 16'h4444;
    rreq_a_valid_i = 1'b1; rreq_a_addr_i = 8'h10; ra_exp = 16'hBEEF;
    tick();
    chk("t4_wgrant_a", 32'(ga), 32'd1);
    chk("t4_rstall_a", 32'(gra), 32'd0);
    chk("t4_wen_a", 32'(buf_wen_a_o), 32'd0);
    wreq_a_valid_i = 1'b0;
    tick();
    chk("t4_rgrant_a", 32'(gra), 32'd1);
    chk("t4_rd_wen_a", 32'(buf_wen_a_o), 32'd1);
    chk("t4_raddr_a", 32'(buf_raddr_a_o), 32'h10);
    rreq_a_valid_i = 1'b0;
    idle(); idle();

    // Preload 0..7 then 8 back-to-back reads on both ports
    for (int i = 0; i < 4; i++) begin
      wreq_a_valid_i = 1'b1; wreq_a_addr_i = 8'(i);     wreq_a_data_i = 16'(32'h5A00 + i);
      wreq_b_valid_i = 1'b1; wreq_b_addr_i = 8'(i + 4); wreq_b_data_i = 16'(32'h5A04 + i);
      tick();
      chk("t5_wgrant", 32'({ga, gb}), 32'd3);
    end
    wreq_a_valid_i = 1'b0; wreq_b_valid_i = 1'b0;
    chk("t5_cen_pre", 32'(buf_cen_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rreq_a_valid_i = 1'b1; rreq_a_addr_i = 8'(i);     ra_exp = 16'(32'h5A00 + i);
      rreq_b_valid_i = 1'b1; rreq_b_addr_i = 8'(7 - i); rb_exp = 16'(32'h5A07 - i);
      tick();
      chk("t5_rgrant", 32'({gra, grb}), 32'd3);
      chk("t5_cen", 32'(buf_cen_o), 32'd1);
    end
    idle();
    chk("t5_cen_last", 32'(buf_cen_o), 32'd1);
    idle();
    chk("t5_cen_off", 32'(buf_cen_o), 32'd0);
    idle();

    // Reset with two reads in flight
    rreq_a_valid_i = 1'b1; rreq_a_addr_i = 8'h00; ra_exp = 16'h5A00;
    rreq_b_valid_i = 1'b1; rreq_b_addr_i = 8'h01; rb_exp = 16'h5A01;
    tick();
    chk("t6_rgrant", 32'({gra, grb}), 32'd3);
    rreq_a_valid_i = 1'b0; rreq_b_valid_i = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("t6_wen_a", 32'(buf_wen_a_o), 32'd1);
    chk("t6_wen_b", 32'(buf_wen_b_o), 32'd1);
    chk("t6_cen", 32'(buf_cen_o), 32'd0);
    chk("t6_waddr_a", 32'(buf_waddr_a_o), 32'd0);
    chk("t6_wdata_a", 32'(buf_wdata_a_o), 32'd0);
    chk("t6_raddr_a", 32'(buf_raddr_a_o), 32'd0);
    chk("t6_raddr_b", 32'(buf_raddr_b_o), 32'd0);
    chk("t6_rvalid_a", 32'(rresp_a_valid_o), 32'd0);
    chk("t6_wready_a", 32'(wreq_a_ready_o), 32'd0);
    chk("t6_rready_a", 32'(rreq_a_ready_o), 32'd0);
    q_a.delete(); q_b.delete();
    @(negedge clk_i);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t6_no_resp", 32'({rresp_a_valid_o, rresp_b_valid_o}), 32'd0);
    end

    // Post-reset read of data written before reset
    rreq_a_valid_i = 1'b1; rreq_a_addr_i = 8'h40; ra_exp = 16'h4444;
    tick();
    chk("t7_rgrant_a", 32'(gra), 32'd1);
    rreq_a_valid_i = 1'b0;

    for (int i = 0; i < 10 && (q_a.size() != 0 || q_b.size() != 0); i++) idle();
    chk("drain_a", 32'(q_a.size()), 32'd0);
    chk("drain_b", 32'(q_b.size()), 32'd0);
    chk("final_err", 32'(err_conflict_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
